// File: rtl/arb_rr_tagged.sv
// N-requester memory arbiter: round-robin or fixed-priority grant into a single
// registered request slot, with per-read transaction IDs used to route responses back.
module arb_rr_tagged #(
  parameter int NUM_REQ    = 2,
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ID_WIDTH   = 2,
  parameter int RR_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_enable,
  input  logic [NUM_REQ-1:0]            i_req_write,
  input  logic [NUM_REQ*PA_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*LINE_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_grant,
  output logic [ID_WIDTH-1:0]           o_req_id,
  output logic                          o_mem_enable,
  output logic                          o_mem_write,
  output logic [PA_WIDTH-1:0]           o_mem_addr,
  output logic [LINE_WIDTH-1:0]         o_mem_data,
  output logic [ID_WIDTH-1:0]           o_mem_id,
  input  logic                          i_mem_full,
  input  logic                          i_mem_resp_enable,
  input  logic [ID_WIDTH-1:0]           i_mem_resp_id,
  input  logic [LINE_WIDTH-1:0]         i_mem_resp_data,
  output logic [NUM_REQ-1:0]            o_resp_enable,
  output logic [LINE_WIDTH-1:0]         o_resp_data,
  output logic [ID_WIDTH-1:0]           o_resp_id,
  output logic [ID_WIDTH:0]             o_outstanding,
  output logic                          o_err_spurious
);

  localparam int NUM_IDS = 1 << ID_WIDTH;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OUT_W   = ID_WIDTH + 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [PA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [ID_WIDTH-1:0]   mem_id_q, mem_id_d;
  logic [NUM_IDS-1:0]    id_valid_q, id_valid_d;
  logic [PTR_W-1:0]      id_owner_q [NUM_IDS];
  logic [PTR_W-1:0]      id_owner_d [NUM_IDS];
  logic [NUM_REQ-1:0]    resp_enable_q, resp_enable_d;
  logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic                  err_spurious_q, err_spurious_d;

  logic                  load_ok;
  logic                  free_exists;
  logic [ID_WIDTH-1:0]   free_id;
  logic [NUM_REQ-1:0]    eligible;
  logic                  found_lo, found_hi;
  logic [PTR_W-1:0]      win_lo, win_hi, win;
  logic                  grant_valid, grant_read;
  logic                  sel_write;
  logic [PA_WIDTH-1:0]   sel_addr;
  logic [LINE_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]    req_grant;
  logic                  resp_hit;

  assign load_ok  = !mem_enable_q || !i_mem_full;
  assign resp_hit = i_mem_resp_enable && id_valid_q[i_mem_resp_id];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    free_exists = 1'b0;
    free_id     = '0;
    for (int j = NUM_IDS - 1; j >= 0; j--) begin
      if (!id_valid_q[j]) begin
        free_exists = 1'b1;
        free_id     = ID_WIDTH'(j);
      end
    end
  end

  // Two passes: lowest eligible at/above the pointer, else lowest overall (the wrap).
  always_comb begin
    eligible = i_req_enable & (i_req_write | {NUM_REQ{free_exists}});
    found_lo = 1'b0;
    found_hi = 1'b0;
    win_lo   = '0;
    win_hi   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found_lo = 1'b1;
        win_lo   = PTR_W'(i);
        if (PTR_W'(i) >= ptr_q) begin
          found_hi = 1'b1;
          win_hi   = PTR_W'(i);
        end
      end
    end
    win         = (RR_MODE != 0 && found_hi) ? win_hi : win_lo;
    grant_valid = load_ok && found_lo && !rst;
  end

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    req_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_write    = i_req_write[i];
        sel_addr     = i_req_addr[i*PA_WIDTH +: PA_WIDTH];
        sel_data     = i_req_data[i*LINE_WIDTH +: LINE_WIDTH];
        req_grant[i] = grant_valid;
      end
    end
  end

  assign grant_read  = grant_valid && !sel_write;
  assign o_req_grant = req_grant;
  assign o_req_id    = grant_read ? free_id : '0;

  always_comb begin
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_id_d     = mem_id_q;
    ptr_d        = ptr_q;
    if (load_ok) begin
      mem_enable_d = grant_valid;
      if (grant_valid) begin
        mem_write_d = sel_write;
        mem_addr_d  = sel_addr;
        mem_data_d  = sel_data;
        mem_id_d    = grant_read ? free_id : '0;
        ptr_d       = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      end
    end
  end

  // Allocation picks from the pre-edge table, so it can never collide with the ID freed here.
  always_comb begin
    id_valid_d     = id_valid_q;
    id_owner_d     = id_owner_q;
    resp_enable_d  = '0;
    resp_data_d    = resp_data_q;
    resp_id_d      = resp_id_q;
    err_spurious_d = i_mem_resp_enable && !resp_hit;
    outstanding_d  = outstanding_q;
    if (resp_hit) begin
      id_valid_d[i_mem_resp_id] = 1'b0;
      resp_data_d               = i_mem_resp_data;
      resp_id_d                 = i_mem_resp_id;
      for (int i = 0; i < NUM_REQ; i++) begin
        resp_enable_d[i] = (id_owner_q[i_mem_resp_id] == PTR_W'(i));
      end
    end
    if (grant_read) begin
      id_valid_d[free_id] = 1'b1;
      id_owner_d[free_id] = win;
    end
    case ({grant_read, resp_hit})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      mem_enable_q   <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_id_q       <= '0;
      id_valid_q     <= '0;
      // NOTE: the owner table is a handful of flops, so it is cleared with the valid bits rather than left X.
      for (int j = 0; j < NUM_IDS; j++) id_owner_q[j] <= '0;
      resp_enable_q  <= '0;
      resp_data_q    <= '0;
      resp_id_q      <= '0;
      outstanding_q  <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      mem_enable_q   <= mem_enable_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      mem_id_q       <= mem_id_d;
      id_valid_q     <= id_valid_d;
      id_owner_q     <= id_owner_d;
      resp_enable_q  <= resp_enable_d;
      resp_data_q    <= resp_data_d;
      resp_id_q      <= resp_id_d;
      outstanding_q  <= outstanding_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  assign o_mem_enable   = mem_enable_q;
  assign o_mem_write    = mem_write_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_data     = mem_data_q;
  assign o_mem_id       = mem_id_q;
  assign o_resp_enable  = resp_enable_q;
  assign o_resp_data    = resp_data_q;
  assign o_resp_id      = resp_id_q;
  assign o_outstanding  = outstanding_q;
  assign o_err_spurious = err_spurious_q;

endmodule

// File: tb/tb_arb_rr_tagged.sv
// Scoreboard bench for arb_rr_tagged: a round-robin and a fixed-priority instance share
// randomized stimulus; a transaction-level model predicts grants, memory traffic and responses.
module tb_arb_rr_tagged;

  localparam int N    = 3;
  localparam int PA   = 32;
  localparam int LW   = 128;
  localparam int IW   = 2;
  localparam int NIDS = 4;

  typedef struct { int who; logic [IW-1:0] id; } grant_t;
  typedef struct { logic wr; logic [PA-1:0] addr; logic [LW-1:0] data; logic [IW-1:0] id; } mem_txn_t;
  typedef struct { int who; logic [LW-1:0] data; logic [IW-1:0] id; } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            sel_fp;
  logic [N-1:0]    req_enable, req_write;
  logic [N*PA-1:0] req_addr;
  logic [N*LW-1:0] req_data;
  logic            mem_full, mem_resp_enable;
  logic [IW-1:0]   mem_resp_id;
  logic [LW-1:0]   mem_resp_data;

  logic [N-1:0]  rr_grant, fp_grant, m_grant;
  logic [IW-1:0] rr_req_id, fp_req_id, m_req_id;
  logic          rr_mem_en, fp_mem_en, m_mem_en;
  logic          rr_mem_wr, fp_mem_wr, m_mem_wr;
  logic [PA-1:0] rr_mem_addr, fp_mem_addr, m_mem_addr;
  logic [LW-1:0] rr_mem_data, fp_mem_data, m_mem_data;
  logic [IW-1:0] rr_mem_id, fp_mem_id, m_mem_id;
  logic [N-1:0]  rr_resp_en, fp_resp_en, m_resp_en;
  logic [LW-1:0] rr_resp_data, fp_resp_data, m_resp_data;
  logic [IW-1:0] rr_resp_id, fp_resp_id, m_resp_id;
  logic [IW:0]   rr_out, fp_out, m_out;
  logic          rr_err, fp_err, m_err;

  wire [N-1:0] rr_req_en  = sel_fp ? '0 : req_enable;
  wire [N-1:0] fp_req_en  = sel_fp ? req_enable : '0;
  wire         rr_resp_in = !sel_fp && mem_resp_enable;
  wire         fp_resp_in = sel_fp && mem_resp_enable;

  arb_rr_tagged #(.NUM_REQ(N), .PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .i_req_enable(rr_req_en), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_grant(rr_grant), .o_req_id(rr_req_id),
    .o_mem_enable(rr_mem_en), .o_mem_write(rr_mem_wr), .o_mem_addr(rr_mem_addr),
    .o_mem_data(rr_mem_data), .o_mem_id(rr_mem_id), .i_mem_full(mem_full),
    .i_mem_resp_enable(rr_resp_in), .i_mem_resp_id(mem_resp_id), .i_mem_resp_data(mem_resp_data),
    .o_resp_enable(rr_resp_en), .o_resp_data(rr_resp_data), .o_resp_id(rr_resp_id),
    .o_outstanding(rr_out), .o_err_spurious(rr_err)
  );

  arb_rr_tagged #(.NUM_REQ(N), .PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst),
    .i_req_enable(fp_req_en), .i_req_write(req_write), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_grant(fp_grant), .o_req_id(fp_req_id),
    .o_mem_enable(fp_mem_en), .o_mem_write(fp_mem_wr), .o_mem_addr(fp_mem_addr),
    .o_mem_data(fp_mem_data), .o_mem_id(fp_mem_id), .i_mem_full(mem_full),
    .i_mem_resp_enable(fp_resp_in), .i_mem_resp_id(mem_resp_id), .i_mem_resp_data(mem_resp_data),
    .o_resp_enable(fp_resp_en), .o_resp_data(fp_resp_data), .o_resp_id(fp_resp_id),
    .o_outstanding(fp_out), .o_err_spurious(fp_err)
  );

  assign m_grant     = sel_fp ? fp_grant     : rr_grant;
  assign m_req_id    = sel_fp ? fp_req_id    : rr_req_id;
  assign m_mem_en    = sel_fp ? fp_mem_en    : rr_mem_en;
  assign m_mem_wr    = sel_fp ? fp_mem_wr    : rr_mem_wr;
  assign m_mem_addr  = sel_fp ? fp_mem_addr  : rr_mem_addr;
  assign m_mem_data  = sel_fp ? fp_mem_data  : rr_mem_data;
  assign m_mem_id    = sel_fp ? fp_mem_id    : rr_mem_id;
  assign m_resp_en   = sel_fp ? fp_resp_en   : rr_resp_en;
  assign m_resp_data = sel_fp ? fp_resp_data : rr_resp_data;
  assign m_resp_id   = sel_fp ? fp_resp_id   : rr_resp_id;
  assign m_out       = sel_fp ? fp_out       : rr_out;
  assign m_err       = sel_fp ? fp_err       : rr_err;

  // Reference model state: ID ownership, RR pointer, request slot occupancy.
  grant_t        q_grant[$];
  mem_txn_t      q_mem[$];
  resp_t         q_resp[$];
  logic [IW-1:0] q_spur[$];
  bit            busy[NIDS];
  int            id_owner[NIDS];
  int            rr_ptr;
  bit            slot_full;
  int            exp_out;

  bit            r_en[N];
  bit            r_wr[N];
  logic [PA-1:0] r_addr[N];
  logic [LW-1:0] r_data[N];
  int            p_req, p_write, p_full, p_resp, p_spur;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic new_req(input int i);
    r_en[i]   = roll(p_req);
    r_wr[i]   = roll(p_write);
    r_addr[i] = $urandom & 32'hFFFF_FFF0;
    r_data[i] = rand_line();
  endtask

  task automatic idle_inputs();
    req_enable      = '0;
    req_write       = '0;
    req_addr        = '0;
    req_data        = '0;
    mem_full        = 1'b0;
    mem_resp_enable = 1'b0;
    mem_resp_id     = '0;
    mem_resp_data   = '0;
  endtask

  task automatic do_reset(input bit fp);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    for (int j = 0; j < NIDS; j++) begin
      busy[j]     = 1'b0;
      id_owner[j] = 0;
    end
    for (int i = 0; i < N; i++) r_en[i] = 1'b0;
    rr_ptr    = 0;
    slot_full = 1'b0;
    exp_out   = 0;
    q_grant.delete();
    q_mem.delete();
    q_resp.delete();
    q_spur.delete();
    #1;
    sel_fp = fp;
    #1;
    check("rst_grant",     256'(m_grant),     256'(0));
    check("rst_mem_en",    256'(m_mem_en),    256'(0));
    check("rst_mem_wr",    256'(m_mem_wr),    256'(0));
    check("rst_mem_addr",  256'(m_mem_addr),  256'(0));
    check("rst_mem_data",  256'(m_mem_data),  256'(0));
    check("rst_mem_id",    256'(m_mem_id),    256'(0));
    check("rst_resp_en",   256'(m_resp_en),   256'(0));
    check("rst_resp_data", 256'(m_resp_data), 256'(0));
    check("rst_resp_id",   256'(m_resp_id),   256'(0));
    check("rst_outstand",  256'(m_out),       256'(0));
    check("rst_spurious",  256'(m_err),       256'(0));
  endtask

  // One clock: drive at negedge, predict, then commit model state at posedge.
  task automatic cycle();
    int            cands[$];
    int            w, r;
    bit            grant, is_rd, load, any_free, resp_en;
    logic [IW-1:0] fid, rid, gid;
    logic [LW-1:0] rdata;
    grant_t        g;
    @(negedge clk);
    rst     = 1'b0;
    resp_en = 1'b0;
    rid     = '0;
    rdata   = rand_line();
    if (roll(p_resp)) begin
      if (roll(p_spur)) begin
        resp_en = 1'b1;
        rid     = IW'($urandom_range(NIDS - 1));
      end else begin
        for (int j = 0; j < NIDS; j++) if (busy[j]) cands.push_back(j);
        if (cands.size() > 0) begin
          resp_en = 1'b1;
          rid     = IW'(cands[$urandom_range(cands.size() - 1)]);
        end
      end
    end
    mem_full = roll(p_full);
    for (int i = 0; i < N; i++) begin
      req_enable[i]          = r_en[i];
      req_write[i]           = r_wr[i];
      req_addr[i*PA +: PA]   = r_addr[i];
      req_data[i*LW +: LW]   = r_data[i];
    end
    mem_resp_enable = resp_en;
    mem_resp_id     = rid;
    mem_resp_data   = rdata;

    any_free = 1'b0;
    fid      = '0;
    for (int j = 0; j < NIDS; j++) begin
      if (!busy[j] && !any_free) begin
        any_free = 1'b1;
        fid      = IW'(j);
      end
    end
    load  = !slot_full || !mem_full;
    grant = 1'b0;
    w     = 0;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        r = sel_fp ? k : (rr_ptr + k) % N;
        if (!grant && r_en[r] && (r_wr[r] || any_free)) begin
          grant = 1'b1;
          w     = r;
        end
      end
    end
    is_rd = grant && !r_wr[w];
    gid   = is_rd ? fid : '0;
    if (grant) begin
      g.who = w;
      g.id  = gid;
      q_grant.push_back(g);
    end

    @(posedge clk);
    if (resp_en) begin
      if (busy[rid]) begin
        q_resp.push_back('{who: id_owner[rid], data: rdata, id: rid});
        busy[rid] = 1'b0;
      end else begin
        q_spur.push_back(rid);
      end
    end
    if (grant) begin
      q_mem.push_back('{wr: r_wr[w], addr: r_addr[w], data: r_data[w], id: gid});
      rr_ptr = (w + 1) % N;
      if (is_rd) begin
        busy[fid]     = 1'b1;
        id_owner[fid] = w;
      end
      new_req(w);
    end
    if (load) slot_full = grant;
    exp_out = 0;
    for (int j = 0; j < NIDS; j++) exp_out += int'(busy[j]);
    for (int i = 0; i < N; i++) if (!r_en[i]) new_req(i);
  endtask

  task automatic run(input int cycles, input int preq, input int pwr, input int pfull,
                     input int presp, input int pspur);
    p_req   = preq;
    p_write = pwr;
    p_full  = pfull;
    p_resp  = presp;
    p_spur  = pspur;
    for (int i = 0; i < N; i++) if (!r_en[i]) new_req(i);
    for (int c = 0; c < cycles; c++) cycle();
  endtask

  // Monitor: compares DUT outputs against queued expectations, away from the active edge.
  initial begin
    grant_t   g;
    mem_txn_t mt;
    resp_t    rs;
    logic [IW-1:0] sid;
    forever begin
      @(negedge clk);
      #2;
      if (q_grant.size() > 0) begin
        g = q_grant.pop_front();
        check("grant",    256'(m_grant),  256'(N'(1) << g.who));
        check("grant_id", 256'(m_req_id), 256'(g.id));
      end else begin
        check("no_grant", 256'(m_grant), 256'(0));
      end

      check("mem_enable", 256'(m_mem_en), 256'(q_mem.size() > 0));
      if (q_mem.size() > 0 && m_mem_en) begin
        mt = q_mem[0];
        check("mem_write", 256'(m_mem_wr),   256'(mt.wr));
        check("mem_addr",  256'(m_mem_addr), 256'(mt.addr));
        check("mem_data",  256'(m_mem_data), 256'(mt.data));
        check("mem_id",    256'(m_mem_id),   256'(mt.id));
        if (!mem_full) void'(q_mem.pop_front());
      end

      if (q_resp.size() > 0) begin
        rs = q_resp.pop_front();
        check("resp_enable", 256'(m_resp_en),   256'(N'(1) << rs.who));
        check("resp_data",   256'(m_resp_data), 256'(rs.data));
        check("resp_id",     256'(m_resp_id),   256'(rs.id));
      end else begin
        check("no_resp", 256'(m_resp_en), 256'(0));
      end

      if (q_spur.size() > 0) begin
        sid = q_spur.pop_front();
        check("spurious", 256'(m_err), 256'(1));
      end else begin
        check("no_spurious", 256'(m_err), 256'(0));
      end

      check("outstanding", 256'(m_out), 256'(exp_out));
    end
  end

  initial begin
    rst    = 1'b1;
    sel_fp = 1'b0;
    idle_inputs();
    do_reset(1'b0);

    // Round-robin: all reading fills the ID table, then writes still pass while reads block.
    run(10, 100, 0, 0, 0, 0);
    run(10, 100, 50, 0, 0, 0);
    // Heavy back-pressure with a trickle of responses.
    run(30, 100, 30, 70, 25, 0);
    run(1500, 60, 30, 25, 40, 10);

    // Mid-stream reset; every response afterwards is for a pre-reset ID and must be flagged.
    do_reset(1'b0);
    run(4, 0, 0, 0, 100, 100);
    run(300, 60, 30, 25, 40, 10);

    // Fixed priority: continuous writers, requester 0 must win every cycle.
    do_reset(1'b1);
    run(20, 100, 100, 0, 0, 0);
    run(1500, 70, 30, 25, 40, 10);
    do_reset(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_rr_tagged.md
Name: arb_rr_tagged

Overview:
- N-requester memory arbiter; successor of the two-port instruction/data arbiter.
- Sits between the instruction/data memory engines (plus future requesters such as a prefetcher or page walker) and the pipelined memory model.
- Arbitrates round-robin or fixed-priority and registers one request toward memory with back-pressure.
- Allocates a free transaction ID per read and routes memory responses back to the owning requester by ID.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
PA_WIDTH, 32, physical address width
LINE_WIDTH, 128, cache-line data width
ID_WIDTH, 2, transaction ID width; 2**ID_WIDTH IDs in flight max
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_enable  in  NUM_REQ  per-requester request valid; held until granted
i_req_write  in  NUM_REQ  1 = line write, 0 = line read
i_req_addr  in  NUM_REQ*PA_WIDTH  packed addresses, requester i at [i*PA_WIDTH +: PA_WIDTH]
i_req_data  in  NUM_REQ*LINE_WIDTH  packed write lines
o_req_grant  out  NUM_REQ  one-hot pulse: request captured this cycle
o_req_id  out  ID_WIDTH  ID assigned to the granted read (valid with grant)
o_mem_enable  out  1  registered request valid toward memory
o_mem_write  out  1  registered write flag
o_mem_addr  out  PA_WIDTH  registered address
o_mem_data  out  LINE_WIDTH  registered write data
o_mem_id  out  ID_WIDTH  registered ID (0 for writes)
i_mem_full  in  1  memory cannot accept; holds output register
i_mem_resp_enable  in  1  read response valid
i_mem_resp_id  in  ID_WIDTH  response ID
i_mem_resp_data  in  LINE_WIDTH  response line
o_resp_enable  out  NUM_REQ  one-hot registered response strobe to owner
o_resp_data  out  LINE_WIDTH  registered response line (shared)
o_resp_id  out  ID_WIDTH  registered response ID
o_outstanding  out  ID_WIDTH+1  count of allocated IDs
o_err_spurious  out  1  pulse: response with an unallocated ID

Behaviour:
- Reset (synchronous, rst high at posedge):
  - All outputs 0; o_mem_* register invalid.
  - ID table (valid bit + owner index per ID) cleared.
  - RR pointer = 0.
  - A response arriving after reset for a pre-reset ID is spurious.
- Acceptance: memory takes the output register at a posedge where o_mem_enable=1 and i_mem_full=0.
- Load condition: output register may load this cycle if o_mem_enable=0, or o_mem_enable=1 and i_mem_full=0.
- Eligibility: requester i is eligible if i_req_enable[i] and (i_req_write[i] or a free ID exists).
- Arbitration: combinational among eligible requesters, only when the load condition holds.
  - RR_MODE=1: search starts at the RR pointer, ascending with wrap.
  - RR_MODE=0: lowest index wins.
- Grant: o_req_grant[w] and o_req_id are combinational in the grant cycle. Latency: request at cycle t, o_mem_enable at t+1.
- Register load: output register loads requester w's fields at the posedge. RR pointer becomes (w+1) mod NUM_REQ. Pointer unchanged when nothing is granted.
- i_mem_full=1 with o_mem_enable=1: output register and pointer frozen; no grants.
- ID allocation (reads only): lowest-index free ID; marked valid with owner w at the grant posedge. Writes allocate nothing, o_mem_id=0.
- ID table full: reads are ineligible; writes may still be granted.
- Response with a valid ID at cycle t:
  - At t+1: o_resp_enable[owner]=1 for one cycle; o_resp_data and o_resp_id carry the response.
  - The ID is freed at the same posedge.
- Response with an invalid ID: dropped; o_err_spurious=1 at t+1; table unchanged.
- Same-cycle free and allocation: a freed ID becomes allocatable only the cycle after the free. Allocation uses the pre-edge table.
- o_outstanding: registered popcount of valid IDs. It is incremented and decremented in the same cycle when a grant and a free coincide.
- Widths: all packed-port slicing uses i*WIDTH; the pointer is $clog2(NUM_REQ) bits (min 1).

Test Plan:
- NUM_REQ=3, RR_MODE=1, all three reading continuously, i_mem_full=0:
  - -> grants 0,1,2,0 on successive cycles; o_req_id 0,1,2,3.
  - -> o_outstanding reaches 4, then no further read grants until a response arrives.
- Four reads outstanding, requester 2 issues a write (addr 0x40, data 0xA5..): write granted next cycle with o_mem_id=0; reads stay blocked.
- i_mem_full=1 for 3 cycles with requester 1 reading 0x1000:
  - -> o_mem_addr=0x1000 held stable; no grant pulses.
  - -> on release, accepted and the next grant issues the same cycle.
- Response id=1 data 0xDEAD.. (owner requester 1):
  - -> next cycle o_resp_enable=3'b010, o_resp_data=0xDEAD.., o_outstanding decremented.
  - -> ID 1 reusable one cycle later.
- Response with id=3 while ID 3 is free -> o_err_spurious pulse; no o_resp_enable; table unchanged.
- RR_MODE=0, requesters 0 and 2 both continuously writing -> requester 0 granted every cycle, 2 never. Assert rst mid-stream -> all outputs 0 next cycle; o_outstanding=0.
